regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writers: the in-order pipeline writeback and a long-latency unit (divider/load return).
- Long-latency results are buffered in an in-order FIFO and drained into idle write-port cycles.
- Keeps a 32-entry pending-write scoreboard so decode can detect RAW hazards on outstanding long-latency destinations.
- A starvation counter forces a one-cycle pipeline stall so the FIFO always drains.

---
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of signals between the register-file writeback arbiter and the core.
// The slave side is the arbiter. The master side is the pipeline, long-latency unit, decode and register file.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_stall;

    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_waddr;

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              busy1;
    logic              busy2;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        output pipe_stall,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready,
        input  issue_valid, issue_waddr,
        input  rd_addr1, rd_addr2,
        output busy1, busy2,
        output rf_we, rf_waddr, rf_wdata, fifo_count
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        input  pipe_stall,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready,
        output issue_valid, issue_waddr,
        output rd_addr1, rd_addr2,
        input  busy1, busy2,
        input  rf_we, rf_waddr, rf_wdata, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// The pipeline writeback and a buffered long-latency unit share one register-file write port.
// A pending-write scoreboard supports RAW detection, and a starvation stall guarantees the FIFO drains.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int NREG     = 1 << ADDR_W;

    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [STARVE_W-1:0] starve_cnt;
    logic [NREG-1:0]     pending;
    logic [NREG-1:0]     pending_next;

    logic empty;
    logic full;
    logic stall;
    logic pipe_active;
    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));

    always_comb begin
        stall        = 1'b0;
        pipe_active  = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        bus.pipe_stall = 1'b0;
        bus.lu_ready   = 1'b0;
        bus.rf_we      = 1'b0;
        bus.rf_waddr   = '0;
        bus.rf_wdata   = '0;
        bus.busy1      = 1'b0;
        bus.busy2      = 1'b0;
        bus.fifo_count = '0;
        if (!rst) begin
            stall        = !empty && (starve_cnt == STARVE_W'(STARVE_MAX));
            pipe_active  = bus.pipe_we && (bus.pipe_waddr != '0) && !stall;
            pop          = !pipe_active && !empty;
            // Readiness comes from the registered count, so a same-cycle pop never frees a slot.
            push         = bus.lu_valid && !full && (bus.lu_waddr != '0);
            bus.pipe_stall = stall;
            bus.lu_ready   = !full;
            bus.fifo_count = count;
            bus.busy1      = pending[bus.rd_addr1];
            bus.busy2      = pending[bus.rd_addr2];
            if (pipe_active) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.pipe_waddr;
                bus.rf_wdata = bus.pipe_wdata;
            end else if (pop) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = fifo_addr[rd_ptr];
                bus.rf_wdata = fifo_data[rd_ptr];
            end
        end
    end

    // Clear on drain, then set on issue, so a same-cycle reissue keeps the bit pending.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next[fifo_addr[rd_ptr]] = 1'b0;
        end
        if (!rst && bus.issue_valid && (bus.issue_waddr != '0)) begin
            pending_next[bus.issue_waddr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.lu_waddr;
            fifo_data[wr_ptr] <= bus.lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            pending    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            pending <= pending_next;
            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (pipe_active) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Expected register-file writes are queued in hand-computed order.
// A negedge monitor checks each write against the queue.
module tb_regfile_wb_arbiter;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Every register-file write must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.rf_we !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL rf_write_unexpected: got we=%b r%0d=%h, required no write",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_we !== 1'b1 || bus.rf_waddr !== mon_e.addr || bus.rf_wdata !== mon_e.data) begin
                    n_fail++;
                    $display("[TB] FAIL rf_write: got we=%b r%0d=%h, required r%0d=%h",
                             bus.rf_we, bus.rf_waddr, bus.rf_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic p_we, input logic [4:0] p_a, input logic [31:0] p_d,
                                 input logic l_v, input logic [4:0] l_a, input logic [31:0] l_d,
                                 input logic i_v, input logic [4:0] i_a);
        @(posedge clk);
        #1;
        bus.pipe_we     = p_we;
        bus.pipe_waddr  = p_a;
        bus.pipe_wdata  = p_d;
        bus.lu_valid    = l_v;
        bus.lu_waddr    = l_a;
        bus.lu_wdata    = l_d;
        bus.issue_valid = i_v;
        bus.issue_waddr = i_a;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    initial begin
        bus.pipe_we = 0; bus.pipe_waddr = 0; bus.pipe_wdata = 0;
        bus.lu_valid = 0; bus.lu_waddr = 0; bus.lu_wdata = 0;
        bus.issue_valid = 0; bus.issue_waddr = 0;
        bus.rd_addr1 = 0; bus.rd_addr2 = 0;

        // Reset: a pipeline request during reset must not reach the register file.
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3);
        @(negedge clk);
        checkOutput("reset_rf_we", 32'(bus.rf_we), 32'h0);
        checkOutput("reset_stall", 32'(bus.pipe_stall), 32'h0);
        checkOutput("reset_lu_ready", 32'(bus.lu_ready), 32'h0);
        checkOutput("reset_count", 32'(bus.fifo_count), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst = 1'b0;
        bus.rd_addr1 = 5'd3;
        @(negedge clk);
        checkOutput("post_reset_busy", 32'(bus.busy1), 32'h0);
        checkOutput("post_reset_lu_ready", 32'(bus.lu_ready), 32'h1);

        // Idle drain: one push, written the next cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("drain_lu_ready", 32'(bus.lu_ready), 32'h1);
        checkOutput("drain_no_passthru", 32'(bus.rf_we), 32'h0);
        idle();
        expectWrite(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("drain_count_1", 32'(bus.fifo_count), 32'h1);
        idle();
        @(negedge clk);
        checkOutput("drain_count_0", 32'(bus.fifo_count), 32'h0);

        // Priority: r7 waits behind three pipeline writes of r3.
        bus.rd_addr1 = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("prio_busy_b0", 32'(bus.busy1), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            expectWrite(5'd3, 32'h11);
            @(negedge clk);
            checkOutput("prio_busy_blocked", 32'(bus.busy1), 32'h1);
        end
        idle();
        expectWrite(5'd7, 32'h77);
        @(negedge clk);
        checkOutput("prio_busy_pop", 32'(bus.busy1), 32'h1);
        idle();
        @(negedge clk);
        checkOutput("prio_busy_clear", 32'(bus.busy1), 32'h0);

        // Full: four pushes under a busy pipeline, a fifth is refused.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(1 + i), 32'h100 + 32'(i), 1'b1, 5'(10 + i), 32'h1000 + 32'(i), 1'b0, 5'd0);
            expectWrite(5'(1 + i), 32'h100 + 32'(i));
            @(negedge clk);
            checkOutput("full_lu_ready_open", 32'(bus.lu_ready), 32'h1);
        end
        applyStimulus(1'b1, 5'd5, 32'h104, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0);
        expectWrite(5'd5, 32'h104);
        @(negedge clk);
        checkOutput("full_lu_ready", 32'(bus.lu_ready), 32'h0);
        checkOutput("full_count", 32'(bus.fifo_count), 32'h4);
        for (int i = 0; i < 4; i++) begin
            idle();
            expectWrite(5'(10 + i), 32'h1000 + 32'(i));
        end
        @(negedge clk);
        checkOutput("full_count_last", 32'(bus.fifo_count), 32'h1);
        idle();
        @(negedge clk);
        checkOutput("full_count_empty", 32'(bus.fifo_count), 32'h0);

        // Starvation: 8 blocked cycles, then a one-cycle stall on the 9th.
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b1, 5'd2, 32'h200 + 32'(i), (i == 0), 5'd20, 32'hA0, 1'b0, 5'd0);
            if (i == 9) expectWrite(5'd20, 32'hA0);
            else        expectWrite(5'd2, 32'h200 + 32'(i));
            @(negedge clk);
            checkOutput("starve_stall", 32'(bus.pipe_stall), (i == 9) ? 32'h1 : 32'h0);
        end
        checkOutput("starve_count", 32'(bus.fifo_count), 32'h0);
        idle();

        // Scoreboard and r0.
        bus.rd_addr1 = 5'd9;
        bus.rd_addr2 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        @(negedge clk);
        checkOutput("sb_busy_r9", 32'(bus.busy1), 32'h1);
        checkOutput("sb_busy_r0", 32'(bus.busy2), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("sb_r0_lu_ready", 32'(bus.lu_ready), 32'h1);
        checkOutput("sb_busy_r0_after", 32'(bus.busy2), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("sb_r0_dropped", 32'(bus.fifo_count), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        expectWrite(5'd9, 32'h99);
        @(negedge clk);
        checkOutput("sb_busy_pop", 32'(bus.busy1), 32'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("sb_set_wins", 32'(bus.busy1), 32'h1);
        idle();
        expectWrite(5'd9, 32'h9A);
        @(negedge clk);
        checkOutput("sb_busy_pop2", 32'(bus.busy1), 32'h1);
        idle();
        @(negedge clk);
        checkOutput("sb_busy_cleared", 32'(bus.busy1), 32'h0);

        // Reset mid-operation with three buffered results and pending bits.
        bus.rd_addr1 = 5'd11;
        bus.rd_addr2 = 5'd12;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd4, 32'h300 + 32'(i), 1'b1, 5'(11 + i), 32'hB0 + 32'(i), 1'b1, 5'(11 + i));
            expectWrite(5'd4, 32'h300 + 32'(i));
        end
        applyStimulus(1'b1, 5'd4, 32'h303, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd4, 32'h303);
        @(negedge clk);
        checkOutput("midrst_count_pre", 32'(bus.fifo_count), 32'h3);
        checkOutput("midrst_busy_pre", 32'(bus.busy2), 32'h1);
        applyStimulus(1'b1, 5'd4, 32'h304, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rf_we", 32'(bus.rf_we), 32'h0);
        checkOutput("midrst_count", 32'(bus.fifo_count), 32'h0);
        idle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_count", 32'(bus.fifo_count), 32'h0);
        checkOutput("postrst_busy1", 32'(bus.busy1), 32'h0);
        checkOutput("postrst_busy2", 32'(bus.busy2), 32'h0);
        checkOutput("postrst_rf_we", 32'(bus.rf_we), 32'h0);
        idle();
        idle();
        idle();
        @(negedge clk);
        checkOutput("writes_outstanding", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
